// File: rtl/lsu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_arbiter_if
// Brief   : Request/response bundle between the two LSU masters and the
//           LSU port arbiter.
// Revision: 1.0  initial release
// ============================================================================
interface lsu_arbiter_if;
  logic        i_m0_req;
  logic        i_m0_wren;
  logic        i_m0_lock;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic [2:0]  i_m0_op;
  logic        i_m1_req;
  logic        i_m1_wren;
  logic        i_m1_lock;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic [2:0]  i_m1_op;
  logic        o_m0_gnt;
  logic        o_m1_gnt;
  logic        o_m0_rvalid;
  logic        o_m1_rvalid;
  logic [31:0] o_m0_rdata;
  logic [31:0] o_m1_rdata;
  logic        o_lsu_wren;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic [2:0]  o_lsu_op;
  logic [31:0] i_ld_data;
  logic        o_busy;

  modport slave (
    input  i_m0_req, i_m0_wren, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_op,
    input  i_m1_req, i_m1_wren, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_op,
    input  i_ld_data,
    output o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
    output o_lsu_wren, o_lsu_addr, o_st_data, o_lsu_op, o_busy
  );

  modport master (
    output i_m0_req, i_m0_wren, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_op,
    output i_m1_req, i_m1_wren, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_op,
    output i_ld_data,
    input  o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
    input  o_lsu_wren, o_lsu_addr, o_st_data, o_lsu_op, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lsu_arbiter
// Brief   : Two-master LSU port arbiter: fixed priority with m1 aging, lock
//           for atomic sequences, tagged load return. Define LSU_ARB_RR_EN
//           for round-robin arbitration instead of priority plus aging.
// Revision: 1.0  initial release
// ============================================================================
module lsu_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int RD_LAT   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  lsu_arbiter_if.slave bus
);

  localparam logic [0:0] S_UNLOCKED = 1'b0;
  localparam logic [0:0] S_LOCKED   = 1'b1;

  logic [0:0]        r_state;
  logic              r_owner;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pid;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic w_g0, w_g1, w_m1_pri, w_acc, w_acc_wren, w_acc_lock, w_ld_acc;
  logic w_own_req, w_ret_v, w_ret_id, w_rv0, w_rv1;

`ifdef LSU_ARB_RR_EN
  logic r_last;  // 1 = m1 won last, so m0 has priority next contest

  assign w_m1_pri = ~r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_last <= 1'b1;
    else if (w_acc) r_last <= w_g1;
  end
`else
  logic [3:0] r_wait;

  assign w_m1_pri = (r_wait == 4'(MAX_WAIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_wait <= 4'd0;
    else if (!bus.i_m1_req || w_g1)        r_wait <= 4'd0;
    else if (r_wait != 4'(MAX_WAIT))       r_wait <= r_wait + 4'd1;
  end
`endif

  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (r_state == S_LOCKED) begin
      w_g0 = bus.i_m0_req & ~r_owner;
      w_g1 = bus.i_m1_req &  r_owner;
    end else if (bus.i_m0_req && bus.i_m1_req) begin
      w_g1 =  w_m1_pri;
      w_g0 = ~w_m1_pri;
    end else begin
      w_g0 = bus.i_m0_req;
      w_g1 = bus.i_m1_req;
    end
  end

  assign w_acc      = w_g0 | w_g1;
  assign w_acc_wren = w_g1 ? bus.i_m1_wren : bus.i_m0_wren;
  assign w_acc_lock = w_g1 ? bus.i_m1_lock : bus.i_m0_lock;
  assign w_ld_acc   = w_acc & ~w_acc_wren;
  assign w_own_req  = r_owner ? bus.i_m1_req : bus.i_m0_req;

  assign bus.o_m0_gnt   = w_g0;
  assign bus.o_m1_gnt   = w_g1;
  assign bus.o_lsu_wren = (w_g0 & bus.i_m0_wren) | (w_g1 & bus.i_m1_wren);
  assign bus.o_lsu_addr = w_g0 ? bus.i_m0_addr  : (w_g1 ? bus.i_m1_addr  : 32'd0);
  assign bus.o_st_data  = w_g0 ? bus.i_m0_wdata : (w_g1 ? bus.i_m1_wdata : 32'd0);
  assign bus.o_lsu_op   = w_g0 ? bus.i_m0_op    : (w_g1 ? bus.i_m1_op    : 3'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_UNLOCKED;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        S_UNLOCKED: begin
          if (w_acc && w_acc_lock) begin
            r_state <= S_LOCKED;
            r_owner <= w_g1;
          end
        end
        S_LOCKED: begin
          // Owner dropping its request also releases, so a stalled owner cannot wedge the port
          if (!w_own_req || (w_acc && !w_acc_lock)) r_state <= S_UNLOCKED;
        end
        default: r_state <= S_UNLOCKED;
      endcase
    end
  end

  generate
    if (RD_LAT > 1) begin : g_pipe_deep
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pv  <= '0;
          r_pid <= '0;
        end else begin
          r_pv  <= {r_pv[RD_LAT-2:0],  w_ld_acc};
          r_pid <= {r_pid[RD_LAT-2:0], w_g1};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pv  <= '0;
          r_pid <= '0;
        end else begin
          r_pv  <= w_ld_acc;
          r_pid <= w_g1;
        end
      end
    end
  endgenerate

  assign w_ret_v  = r_pv[RD_LAT-1];
  assign w_ret_id = r_pid[RD_LAT-1];
  assign w_rv0    = w_ret_v & ~w_ret_id;
  assign w_rv1    = w_ret_v &  w_ret_id;

  // LSU data is valid in the return cycle; present it then and keep it afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      if (w_rv0) r_rdata0 <= bus.i_ld_data;
      if (w_rv1) r_rdata1 <= bus.i_ld_data;
    end
  end

  assign bus.o_m0_rvalid = w_rv0;
  assign bus.o_m1_rvalid = w_rv1;
  assign bus.o_m0_rdata  = w_rv0 ? bus.i_ld_data : r_rdata0;
  assign bus.o_m1_rdata  = w_rv1 ? bus.i_ld_data : r_rdata1;
  assign bus.o_busy      = (r_state == S_LOCKED) | (|r_pv);

endmodule
`default_nettype wire

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Shares the single LSU load/store port between two requesters: master 0 (core pipeline data path) and master 1 (DMA/debug loader).
- Sits between the masters and the LSU and drives the LSU address, write-enable, store-data and op inputs.
- Arbitration is fixed-priority (m0 wins), with an aging guard against m1 starvation and a lock for atomic multi-beat sequences.
- Load data is returned to the issuing master after a fixed read latency.

Parameters:
- MAX_WAIT, 4: cycles m1 may be refused while requesting before it gets priority; legal range 1..15.
- RD_LAT, 1: cycles from accepted load to valid LSU read data; legal values 1 or 2.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_m0_req / i_m1_req  input  1  master transfer request.
- i_m0_wren / i_m1_wren  input  1  1 = store, 0 = load.
- i_m0_lock / i_m1_lock  input  1  hold ownership after this transfer.
- i_m0_addr / i_m1_addr  input  32  byte address.
- i_m0_wdata / i_m1_wdata  input  32  store data.
- i_m0_op / i_m1_op  input  3  LSU op code; passed through unchanged.
- o_m0_gnt / o_m1_gnt  output  1  transfer accepted this cycle.
- o_m0_rvalid / o_m1_rvalid  output  1  load data valid, one-cycle pulse.
- o_m0_rdata / o_m1_rdata  output  32  load data.
- o_lsu_wren  output  1  LSU write enable.
- o_lsu_addr  output  32  LSU address.
- o_st_data  output  32  LSU store data.
- o_lsu_op  output  3  LSU op code.
- i_ld_data  input  32  LSU load data.
- o_busy  output  1  lock held or a load in flight.

Behaviour:
- Reset (async assert, sync release):
  - lock state = UNLOCKED, owner = none, wait_cnt = 0, read pipeline cleared.
  - All rvalid = 0, rdata = 0, o_busy = 0.
  - In-flight load responses are discarded and never delivered.
- Grant is combinational in the request cycle. A transfer is accepted when req & gnt are both high. At most one gnt is high per cycle.
- Decision order:
  1. LOCKED: only the owner can be granted.
  2. Both requesting: m1 wins if wait_cnt == MAX_WAIT, else m0.
  3. Single requester: it wins.
- LSU outputs mux from the granted master. With no grant: o_lsu_wren = 0, and addr, st_data and op are all 0.
- o_lsu_wren = granted master's wren, gated by gnt. A store never reaches the LSU without an accepting gnt.
- wait_cnt:
  - +1 per cycle while i_m1_req & !o_m1_gnt, saturating at MAX_WAIT.
  - Cleared on an m1 accept or when i_m1_req = 0.
  - Increments during another master's lock.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on an accept with that master's lock = 1; owner = that master.
  - LOCKED -> UNLOCKED on an owner accept with lock = 0, or on any cycle the owner's req = 0.
  - Releasing accept is granted normally; the other master may win the following cycle.
- Read return:
  - Each accepted load pushes {valid, master id} into an RD_LAT-deep shift pipeline.
  - At the pipeline output, the tagged master's rvalid pulses for 1 cycle and its rdata is registered from i_ld_data.
  - rdata holds its value otherwise.
  - Back-to-back loads return in issue order, one per cycle; loads alternating between masters are all delivered.
- Stores produce no rvalid.
- o_busy = LOCKED | any pipeline stage valid.

Optional Feature:
- Macro LSU_ARB_RR_EN.
- Defined: round-robin arbitration replaces fixed priority plus aging.
  - A last-winner register (reset: m1, so m0 wins first) gives priority to the other master on each contested cycle.
  - Updated on every accept.
  - wait_cnt is held at 0.
  - Lock rules are unchanged.
- Undefined: fixed priority with MAX_WAIT aging as above.

Test Plan:
- Reset mid-load: m0 load accepted at cycle 0 with RD_LAT = 1, reset asserted before the return edge -> no rvalid, rdata = 0, o_busy = 0.
- Single m1 store: addr 0x1000_0000, wdata 0xDEAD_BEEF, op 3'b010 -> o_m1_gnt = 1 same cycle, o_lsu_wren = 1, LSU outputs match, no rvalid.
- Contention with MAX_WAIT = 4: both requesting continuously -> m0 granted 4 cycles, m1 granted on cycle 5, wait_cnt back to 0, m0 granted on cycle 6.
- Lock: m1 accepted with lock = 1 for 3 beats then lock = 0, m0 requesting throughout -> o_m0_gnt = 0 for those 4 cycles, m0 granted the cycle after release.
- Loads, RD_LAT = 2, i_ld_data modelled as addr + 1: m0 load addr 0x10 then m1 load addr 0x20 on consecutive cycles -> o_m0_rvalid with 0x11 at cycle 2, o_m1_rvalid with 0x21 at cycle 3.
- LSU_ARB_RR_EN defined: both requesting for 4 cycles -> grants m0, m1, m0, m1.
